// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M iterative divider.
package div_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// stalls the front end while busy and pulses done with the writeback data.
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  kill,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [4:0]            rd_in,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  div_state_t      state_r, next_state_s;
  div_op_t         op_r;
  logic [4:0]      rd_r;
  logic [W-1:0]    quo_r, rem_r, dvs_r;
  logic [CW-1:0]   count_r;
  logic            neg_q_r, neg_r_r;

  logic            accept_s, signed_s, div_zero_s, ovf_s, special_s;
  logic [W-1:0]    a_abs_s, b_abs_s, special_res_s;
  logic [2*W-1:0]  step_s;
  logic [W-1:0]    q_fin_s, r_fin_s, calc_res_s;

  // Shift {rem, quo} left one bit and trial-subtract the divisor; returns {rem, quo}.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                              input logic [W-1:0] quo,
                                              input logic [W-1:0] dvs);
    logic [W:0] shifted;
    logic [W:0] trial;
    shifted = {rem, quo[W-1]};
    trial   = shifted - {1'b0, dvs};
    if (trial[W] == 1'b0) begin
      div_step = {trial[W-1:0], quo[W-2:0], 1'b1};
    end else begin
      div_step = {shifted[W-1:0], quo[W-2:0], 1'b0};
    end
  endfunction

  // Operand conditioning, special-case detection and final sign correction.
  always_comb begin
    accept_s   = (state_r == IDLE) && start && !kill;
    signed_s   = (div_op[0] == 1'b0);
    div_zero_s = (divisor == '0);
    ovf_s      = signed_s && (dividend == W'(INT_MIN)) && (divisor == W'(DIV_ZERO_Q));
    special_s  = div_zero_s || ovf_s;
    a_abs_s    = (signed_s && dividend[W-1]) ? -dividend : dividend;
    b_abs_s    = (signed_s && divisor[W-1])  ? -divisor  : divisor;
    if (div_op[1] == 1'b1) begin
      special_res_s = div_zero_s ? dividend : '0;
    end else begin
      special_res_s = div_zero_s ? W'(DIV_ZERO_Q) : W'(INT_MIN);
    end
    step_s  = div_step(rem_r, quo_r, dvs_r);
    q_fin_s = neg_q_r ? -step_s[W-1:0]   : step_s[W-1:0];
    r_fin_s = neg_r_r ? -step_s[2*W-1:W] : step_s[2*W-1:W];
    if ((op_r == REM) || (op_r == REMU)) begin
      calc_res_s = r_fin_s;
    end else begin
      calc_res_s = q_fin_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; kill always returns to IDLE and outranks start.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = special_s ? DONE : CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (kill) begin
          next_state_s = IDLE;
        end else if (count_r == '0) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CALC;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Stall is combinational on start so decode holds on the accepting edge.
  always_comb begin
    stall = accept_s || (state_r == CALC);
    done  = (state_r == DONE);
  end

  // Datapath: operand capture, iteration, and writeback registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r    <= DIV;
      rd_r    <= 5'd0;
      quo_r   <= '0;
      rem_r   <= '0;
      dvs_r   <= '0;
      count_r <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      result  <= '0;
      rd_out  <= 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r    <= div_op_t'(div_op);
            rd_r    <= rd_in;
            quo_r   <= a_abs_s;
            dvs_r   <= b_abs_s;
            rem_r   <= '0;
            count_r <= CW'(DATA_WIDTH - 1);
            neg_q_r <= signed_s && (dividend[W-1] ^ divisor[W-1]);
            neg_r_r <= signed_s && dividend[W-1];
            if (special_s) begin
              result <= special_res_s;
              rd_out <= rd_in;
            end
          end
        end
        CALC: begin
          if (!kill) begin
            {rem_r, quo_r} <= step_s;
            if (count_r == '0) begin
              result <= calc_res_s;
              rd_out <= rd_r;
            end else begin
              count_r <= count_r - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
